move_controller: RTL and testbench
==================================

// Module: move_controller
// PURPOSE
//  Sequences the 10-bit position counter (moveCounter) from player buttons and a recenter command.
//  Emits one-cycle step pulses on ctrl (00=movL, 01=movR, 11=hold) at a fixed step rate.
//  Clamps motion to [X_MIN, X_MAX] using position feedback, and arbitrates recenter over player input.
//  Sits between the debounced button inputs and the position counter, in the clk domain.
// PARAMETERS
//  POS_W       10      position width; must match the counter width
//  X_MIN       0       lowest legal position
//  X_MAX       639     highest legal position
//  HOME        319     recenter target; equals the counter reset value
//  STEP_DIV    200000  clk cycles between steps; legal range >= 2
//  DIV_W       18      step-timer width; must satisfy 2**DIV_W > STEP_DIV
//  ACCEL_STEPS 16      consecutive steps before acceleration (MOVE_ACCEL_EN only)
// PORTS
//  clk       in   1      system clock
//  reset     in   1      asynchronous reset, active-low
//  btnL      in   1      level, synchronised: move left while high
//  btnR      in   1      level, synchronised: move right while high
//  recenter  in   1      one-cycle pulse: return to HOME
//  pos       in   POS_W  current counter value (cntVal feedback)
//  ctrl      out  2      to counter: 00=movL, 01=movR, 11=hold; registered
//  busy      out  1      high while in RECENTER; registered
//  at_min    out  1      combinational: pos <= X_MIN
//  at_max    out  1      combinational: pos >= X_MAX
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, ctrl=11, busy=0, timer=0, accel count=0. Applies immediately, including mid-move.
//  Step pulse: ctrl=00/01 for exactly 1 cycle per step; 11 at all other times. Never 10.
//  States:
//   IDLE -> RECENTER if recenter && pos!=HOME.
//   IDLE -> MOVE_L if btnL && !btnR && pos>X_MIN; -> MOVE_R symmetric.
//   MOVE_L/MOVE_R -> IDLE on button release, on both buttons high, or on the bound being reached.
//   Any state -> RECENTER on recenter pulse when pos!=HOME; recenter has priority over buttons.
//   RECENTER -> IDLE when pos==HOME. Buttons are ignored in RECENTER. recenter with pos==HOME is a no-op.
//  Timing:
//   First pulse is issued in the cycle after the move/recenter state is entered.
//   Subsequent pulses follow every STEP_DIV cycles. Timer clears on every state change.
//  Clamp: checked at each pulse issue against the current pos. movL is suppressed if pos<=X_MIN; movR if pos>=X_MAX.
//  Out-of-range pos: only steps toward the legal range are emitted.
//  RECENTER direction: movR if pos<HOME, movL if pos>HOME. pos==HOME is checked before each pulse, so no overshoot.
//  Feedback latency: pos updates one cycle after a pulse; STEP_DIV>=2 guarantees fresh pos at the next decision.
// CONFIGURATION
//  MOVE_ACCEL_EN defined:
//   In MOVE_L/MOVE_R, after ACCEL_STEPS consecutive pulses the period becomes STEP_DIV/2.
//   The accel count clears on leaving the state. RECENTER is unaffected.
//  MOVE_ACCEL_EN undefined: fixed STEP_DIV period; no accel counter is built.
// STRUCTURE
//  Package move_pkg:
//   CTRL_MOVL=2'b00, CTRL_MOVR=2'b01, CTRL_HOLD=2'b11 (shared with the counter)
//   State encodings ST_IDLE, ST_MOVE_L, ST_MOVE_R, ST_RECENTER.
//  Sub-module step_timer:
//   Inputs clear and period. Outputs a 1-cycle tick; the first tick comes one cycle after clear, then one every period cycles.
//  Top level: FSM, clamp compare, and ctrl/busy registers.
// TESTING (STEP_DIV=4, X_MIN=0, X_MAX=639, HOME=319, counter model attached)
//  1. Reset asserted -> ctrl=11, busy=0; pos=319. Assert reset mid-move -> ctrl=11 in the same cycle.
//  2. pos=319, hold btnR for 13 cycles -> movR pulses at cycles 1,5,9,13; pos=323; ctrl=11 after release.
//  3. pos=1, hold btnL for 20 cycles -> exactly one movL pulse; pos=0, at_min=1, state IDLE.
//  4. btnL and btnR high together for 20 cycles -> ctrl stays 11; pos unchanged.
//  5. pos=315, btnL held, recenter pulse:
//     busy=1; 4 movR pulses 4 cycles apart; pos=319; busy=0.
//     Then MOVE_L resumes (first movL the cycle after entering MOVE_L).
//  6. MOVE_ACCEL_EN, ACCEL_STEPS=2, btnR held -> pulse spacing 4,4 then 2,2,...; release+re-press restores spacing 4.

Source files
------------

// File: rtl/move_pkg.sv
// Shared definitions for the move controller.
// The ctrl step codes are also decoded by the position counter,
// so they must stay in sync with it.
package move_pkg;

  localparam logic [1:0] CTRL_MOVL = 2'b00;
  localparam logic [1:0] CTRL_MOVR = 2'b01;
  localparam logic [1:0] CTRL_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MOVE_L   = 2'd1,
    ST_MOVE_R   = 2'd2,
    ST_RECENTER = 2'd3
  } move_state_t;

endpackage

// File: rtl/step_timer.sv
// Step-rate timer.
// The tick is high whenever the count sits at zero. A clear parks the
// count at zero, so the first tick lands one cycle after the clear.
// After that, a tick occurs every 'period' cycles.
// The wrap test uses >= so that shortening the period mid-count
// cannot strand the count above the new limit.
module step_timer #(
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Free-running modulo-period counter, restarted by clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count >= period - 1'b1) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/move_controller.sv
// Move controller: turns button levels and recenter pulses into one-cycle
// step pulses for the position counter. Motion is clamped to
// [X_MIN, X_MAX] using the counter's position feedback.
// The optional macro MOVE_ACCEL_EN halves the step period once a move has
// run long enough. Recenter moves always use the base period.
module move_controller
  import move_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int HOME     = 319,
  parameter int STEP_DIV = 200000,
  parameter int DIV_W    = 18
`ifdef MOVE_ACCEL_EN
  ,
  parameter int ACCEL_STEPS = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             recenter,
  input  logic [POS_W-1:0] pos,
  output logic [1:0]       ctrl,
  output logic             busy,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [POS_W-1:0] xMin = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] xMax = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] home = POS_W'(HOME);

  move_state_t      state;
  move_state_t      nextState;
  logic [1:0]       ctrlNext;
  logic             clearTimer;
  logic             tick;
  logic [DIV_W-1:0] period;
  logic             atHome;
  logic             canLeft;
  logic             canRight;

  assign at_min   = (pos <= xMin);
  assign at_max   = (pos >= xMax);
  assign atHome   = (pos == home);
  assign canLeft  = (pos > xMin);
  assign canRight = (pos < xMax);

  // Any state change restarts the step timer so the first pulse of a new move
  // is issued one cycle after the move begins.
  assign clearTimer = (nextState != state);

`ifdef MOVE_ACCEL_EN
  localparam int ACW = $clog2(ACCEL_STEPS + 2);
  logic [ACW-1:0] accelCount;
  logic           moving;

  assign moving = (state == ST_MOVE_L) || (state == ST_MOVE_R);

  // Counts pulses in the current move, saturating one past ACCEL_STEPS.
  // The count clears whenever the state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accelCount <= '0;
    end else if (clearTimer) begin
      accelCount <= '0;
    end else if (moving && (ctrlNext != CTRL_HOLD) && (accelCount <= ACW'(ACCEL_STEPS))) begin
      accelCount <= accelCount + 1'b1;
    end
  end

  // The first pulse starts the run.
  // ACCEL_STEPS full-length intervals follow before the half period applies.
  assign period = (moving && (accelCount > ACW'(ACCEL_STEPS)))
                  ? DIV_W'(STEP_DIV / 2) : DIV_W'(STEP_DIV);
`else
  assign period = DIV_W'(STEP_DIV);
`endif

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clearTimer),
    .period (period),
    .tick   (tick)
  );

  // Next-state selection: recenter outranks the buttons in every state.
  // A move ends on release, on both buttons pressed, or when the bound is reached.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (recenter && !atHome)              nextState = ST_RECENTER;
        else if (btnL && !btnR && canLeft)    nextState = ST_MOVE_L;
        else if (btnR && !btnL && canRight)   nextState = ST_MOVE_R;
      end
      ST_MOVE_L: begin
        if (recenter && !atHome)              nextState = ST_RECENTER;
        else if (!btnL || btnR || !canLeft)   nextState = ST_IDLE;
      end
      ST_MOVE_R: begin
        if (recenter && !atHome)              nextState = ST_RECENTER;
        else if (!btnR || btnL || !canRight)  nextState = ST_IDLE;
      end
      ST_RECENTER: begin
        if (atHome)                           nextState = ST_IDLE;
      end
      default:                                nextState = ST_IDLE;
    endcase
  end

  // Pulse decision on each timer tick. The current position is re-checked
  // here, so a move never steps past a bound. A recenter never steps past home.
  always_comb begin
    ctrlNext = CTRL_HOLD;
    if (tick) begin
      case (state)
        ST_MOVE_L:   if (canLeft)  ctrlNext = CTRL_MOVL;
        ST_MOVE_R:   if (canRight) ctrlNext = CTRL_MOVR;
        ST_RECENTER: begin
          if (pos < home)      ctrlNext = CTRL_MOVR;
          else if (pos > home) ctrlNext = CTRL_MOVL;
        end
        default:               ctrlNext = CTRL_HOLD;
      endcase
    end
  end

  // State register plus registered ctrl and busy outputs.
  // The async reset forces a hold immediately, even mid-pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ctrl  <= CTRL_HOLD;
      busy  <= 1'b0;
    end else begin
      state <= nextState;
      ctrl  <= ctrlNext;
      busy  <= (nextState == ST_RECENTER);
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Testbench for move_controller with a position-counter model attached.
// Run with STEP_DIV=4. Accel checks are compiled only with MOVE_ACCEL_EN.
module tb_move_controller;

  logic       clk;
  logic       reset;
  logic       btnL;
  logic       btnR;
  logic       recenter;
  logic [9:0] pos;
  logic [1:0] ctrl;
  logic       busy;
  logic       at_min;
  logic       at_max;
  logic       loadEn;
  logic [9:0] loadVal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       l;
    logic       r;
    logic       rc;
    logic [1:0] expCtrl;
    logic       expBusy;
    int         expPos;
  } vec_t;

  vec_t vecs[21];

  move_controller #(
    .POS_W(10), .X_MIN(0), .X_MAX(639), .HOME(319), .STEP_DIV(4), .DIV_W(4)
`ifdef MOVE_ACCEL_EN
    , .ACCEL_STEPS(2)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btnL     (btnL),
    .btnR     (btnR),
    .recenter (recenter),
    .pos      (pos),
    .ctrl     (ctrl),
    .busy     (busy),
    .at_min   (at_min),
    .at_max   (at_max)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position counter model: resets to home, follows ctrl steps, and can be preloaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                pos <= 10'd319;
    else if (loadEn)           pos <= loadVal;
    else if (ctrl == 2'b00)    pos <= pos - 10'd1;
    else if (ctrl == 2'b01)    pos <= pos + 10'd1;
  end

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic rc);
    btnL     = l;
    btnR     = r;
    recenter = rc;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  task automatic setPos(input logic [9:0] v);
    loadEn  = 1'b1;
    loadVal = v;
    @(negedge clk);
    loadEn  = 1'b0;
  endtask

  task automatic holdAndCount(input logic l, input logic r, input int n,
                              output int nl, output int nr);
    nl = 0;
    nr = 0;
    applyStimulus(l, r, 1'b0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ctrl == 2'b00) nl++;
      if (ctrl == 2'b01) nr++;
    end
  endtask

  initial begin
    int  nl;
    int  nr;
    int  expC;
    bit  found;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 319};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 319};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 320};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 320};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 320};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 320};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 321};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 321};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 321};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 321};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 322};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 322};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 322};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 322};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 323};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 323};
    for (int i = 16; i < 21; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 323};

    reset   = 1'b0;
    loadEn  = 1'b0;
    loadVal = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", ctrl, 3);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pos", pos, 319);
    checkOutput("reset_at_min", at_min, 0);
    checkOutput("reset_at_max", at_max, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] table: btnR run and both-buttons hold");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].l, vecs[i].r, vecs[i].rc);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_ctrl", i), ctrl, vecs[i].expCtrl);
      checkOutput($sformatf("tbl%0d_busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("tbl%0d_pos", i), pos, vecs[i].expPos);
      checkOutput($sformatf("tbl%0d_at_max", i), at_max, (vecs[i].expPos >= 639) ? 1 : 0);
    end
    idle(3);

    $display("[TB] reset during a move");
    found = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ctrl == 2'b01) found = 1'b1;
    end
    checkOutput("midmove_pulse_seen", found, 1);
    reset = 1'b0;
    #1;
    checkOutput("midmove_reset_ctrl", ctrl, 3);
    checkOutput("midmove_reset_busy", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    checkOutput("midmove_after_pos", pos, 319);

    $display("[TB] left clamp at X_MIN");
    setPos(10'd1);
    holdAndCount(1'b1, 1'b0, 20, nl, nr);
    checkOutput("minclamp_movl_count", nl, 1);
    checkOutput("minclamp_movr_count", nr, 0);
    checkOutput("minclamp_pos", pos, 0);
    checkOutput("minclamp_at_min", at_min, 1);
    checkOutput("minclamp_ctrl", ctrl, 3);
    idle(2);

    $display("[TB] right clamp and out-of-range position");
    setPos(10'd639);
    checkOutput("maxclamp_at_max", at_max, 1);
    holdAndCount(1'b0, 1'b1, 10, nl, nr);
    checkOutput("maxclamp_movr_count", nr, 0);
    checkOutput("maxclamp_pos", pos, 639);
    idle(2);
    setPos(10'd700);
    holdAndCount(1'b0, 1'b1, 6, nl, nr);
    checkOutput("oor_movr_count", nr, 0);
    holdAndCount(1'b1, 1'b0, 6, nl, nr);
    checkOutput("oor_movl_count", nl, 2);
    idle(2);
    checkOutput("oor_pos", pos, 698);
    checkOutput("oor_at_max", at_max, 1);
    idle(2);

    $display("[TB] recenter over held btnL");
    setPos(10'd315);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (k == 2 || k == 6 || k == 10 || k == 14) expC = 1;
      else if (k == 18)                              expC = 0;
      else                                           expC = 3;
      checkOutput($sformatf("rc%0d_ctrl", k), ctrl, expC);
      checkOutput($sformatf("rc%0d_busy", k), busy, (k <= 15) ? 1 : 0);
      if (k == 15) checkOutput("rc_home_pos", pos, 319);
    end
    idle(4);

    $display("[TB] recenter at home is a no-op");
    setPos(10'd319);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("noop%0d_busy", k), busy, 0);
      checkOutput($sformatf("noop%0d_ctrl", k), ctrl, 3);
    end
    checkOutput("noop_pos", pos, 319);

`ifdef MOVE_ACCEL_EN
    $display("[TB] acceleration");
    idle(2);
    setPos(10'd100);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      expC = (k == 2 || k == 6 || k == 10 || k == 12 || k == 14) ? 1 : 3;
      checkOutput($sformatf("acc%0d_ctrl", k), ctrl, expC);
    end
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      expC = (k == 2 || k == 6 || k == 10) ? 1 : 3;
      checkOutput($sformatf("accre%0d_ctrl", k), ctrl, expC);
    end
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
